// File: rtl/ubw_pkg.sv
// ubw_pkg: shared types and constants for the update-bin write-back engine.
//   t_ubw_state : top-level FSM states.
//   t_ubw_req   : one c1 write request (address + line) at the default widths.
//   STATUS_DONE_FLAG : value written to bits [31:0] of the status line.
//   UBW_MAX_BINS     : largest supported bin count (status line must fit 512b).
package ubw_pkg;

  localparam int          UBW_MAX_BINS     = 14;
  localparam logic [31:0] STATUS_DONE_FLAG = 32'h1;
  localparam int          UBW_ADDR_W       = 42;
  localparam int          UBW_DATA_W       = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_STATUS,
    ST_WAIT_RSP
  } t_ubw_state;

  typedef struct packed {
    logic [UBW_ADDR_W-1:0] addr;
    logic [UBW_DATA_W-1:0] data;
  } t_ubw_req;

endpackage

// File: rtl/ubw_req_fifo.sv
// ubw_req_fifo: synchronous show-ahead FIFO holding pending c1 write requests.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only).
//   wr_en, wr_data : push (ignored when full).
//   rd_en          : pop (ignored when empty); rd_data always shows the head.
//   empty, count   : occupancy status.
module ubw_req_fifo
  import ubw_pkg::*;
#(
  parameter int WIDTH = 554,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign wr_ok   = wr_en && (count != (PTR_W+1)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(wr_ok) - (PTR_W+1)'(rd_ok);
    end
  end

endmodule

// File: rtl/update_bin_writer.sv
// update_bin_writer: writes binned update lines to base + bin*stride + fill
// over CCI-P c1, then writes a status line with the per-bin counts and pulses
// done once every write has been acknowledged.
//   clk, reset          : clock, asynchronous active-high reset.
//   start               : begin a job (IDLE only); latches the three config inputs.
//   bin_base_addr, bin_stride_cl, status_addr : job configuration.
//   in_valid/in_bin/in_data/in_last/in_ready  : update stream and flush request.
//   c1_almfull, c1_req_* , c1_rsp_valid        : c1 write channel.
//   busy, done, bin_overflow, bin_count        : job status.
module update_bin_writer
  import ubw_pkg::*;
#(
  parameter int NUM_BINS      = 4,
  parameter int ADDR_W        = 42,
  parameter int DATA_W        = 512,
  parameter int FIFO_DEPTH    = 64,
  parameter int ALMFULL_SLACK = 8,
  localparam int BIN_W        = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     bin_base_addr,
  input  logic [31:0]           bin_stride_cl,
  input  logic [ADDR_W-1:0]     status_addr,
  input  logic                  in_valid,
  input  logic [BIN_W-1:0]      in_bin,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  c1_almfull,
  output logic                  c1_req_valid,
  output logic [ADDR_W-1:0]     c1_req_addr,
  output logic [DATA_W-1:0]     c1_req_data,
  input  logic                  c1_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_BINS-1:0]   bin_overflow,
  output logic [NUM_BINS*32-1:0] bin_count
);

  localparam int REQ_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  t_ubw_state state;
  t_ubw_state state_next;

  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stat_addr;
  logic [31:0]       stride;
  logic [ADDR_W-1:0] off_acc;
  logic [ADDR_W-1:0] bin_off [NUM_BINS];
  logic [31:0]       count   [NUM_BINS];
  logic [BIN_W-1:0]  setup_idx;
  logic [31:0]       req_cnt;
  logic [31:0]       rsp_cnt;
  logic [31:0]       req_next;
  logic [31:0]       rsp_next;
  logic              cnt_match_p1;

  logic              bin_ok;
  logic [BIN_W-1:0]  sel;
  logic [31:0]       sel_cnt;
  logic              accept;
  logic              push;
  logic              ovf_set;
  logic              pop;
  logic              status_fire;
  logic [REQ_W-1:0]  push_req;
  logic [REQ_W-1:0]  head_req;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  free_slots;
  logic [DATA_W-1:0] status_line;
  logic [31:0]       count_sum;

  // ---------------- input acceptance / request build ----------------
  assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign in_ready   = (state == ST_RUN) && (free_slots > CNT_W'(ALMFULL_SLACK));
  assign busy       = (state != ST_IDLE);

  // Out-of-range bins are steered to bin 0 for the lookup but never acted on.
  assign bin_ok   = ({1'b0, in_bin} < (BIN_W+1)'(NUM_BINS));
  assign sel      = bin_ok ? in_bin : '0;
  assign sel_cnt  = count[sel];
  assign accept   = in_ready && in_valid && bin_ok;
  assign push     = accept && (sel_cnt < stride);
  assign ovf_set  = accept && !(sel_cnt < stride);
  assign push_req = {bin_off[sel] + ADDR_W'(sel_cnt), in_data};

  assign pop         = !fifo_empty && !c1_almfull;
  assign status_fire = (state == ST_STATUS) && !c1_almfull;

  assign req_next = req_cnt + 32'(pop) + 32'(status_fire);
  assign rsp_next = rsp_cnt + 32'((state != ST_IDLE) && c1_rsp_valid);

  always_comb begin
    status_line       = '0;
    count_sum         = '0;
    status_line[31:0] = STATUS_DONE_FLAG;
    for (int i = 0; i < NUM_BINS; i++) begin
      count_sum                     = count_sum + count[i];
      status_line[64 + 32*i +: 32]  = count[i];
      bin_count[32*i +: 32]         = count[i];
    end
    status_line[63:32] = count_sum;
  end

  ubw_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_req),
    .rd_en   (pop),
    .rd_data (head_req),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start) state_next = ST_SETUP;
      ST_SETUP:    if (setup_idx == BIN_W'(NUM_BINS - 1)) state_next = ST_RUN;
      ST_RUN:      if (in_ready && in_last) state_next = ST_DRAIN;
      // A pop last cycle still has its request sitting in the output register.
      ST_DRAIN:    if (fifo_empty && !c1_req_valid) state_next = ST_STATUS;
      ST_STATUS:   if (!c1_almfull) state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (cnt_match_p1) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // ---------------- config and bin offset table ----------------
  // Offsets are built by repeated addition, one bin per SETUP cycle.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      base_addr <= bin_base_addr;
      stride    <= bin_stride_cl;
      stat_addr <= status_addr;
      off_acc   <= bin_base_addr;
    end else if (state == ST_SETUP) begin
      bin_off[setup_idx] <= off_acc;
      off_acc            <= off_acc + ADDR_W'(stride);
    end
  end

  // ---------------- counters, flags, c1 output register (p1) ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_req_valid <= 1'b0;
      c1_req_addr  <= '0;
      c1_req_data  <= '0;
      done         <= 1'b0;
      bin_overflow <= '0;
      req_cnt      <= '0;
      rsp_cnt      <= '0;
      cnt_match_p1 <= 1'b0;
      setup_idx    <= '0;
      for (int i = 0; i < NUM_BINS; i++) count[i] <= '0;
    end else begin
      done         <= 1'b0;
      c1_req_valid <= pop || status_fire;
      if (pop) begin
        c1_req_addr <= head_req[DATA_W +: ADDR_W];
        c1_req_data <= head_req[DATA_W-1:0];
      end else if (status_fire) begin
        c1_req_addr <= stat_addr;
        c1_req_data <= status_line;
      end
      if (state == ST_IDLE && start) begin
        bin_overflow <= '0;
        req_cnt      <= '0;
        rsp_cnt      <= '0;
        cnt_match_p1 <= 1'b1;
        setup_idx    <= '0;
        for (int i = 0; i < NUM_BINS; i++) count[i] <= '0;
      end else begin
        req_cnt <= req_next;
        rsp_cnt <= rsp_next;
        // Compare the next values so the flag matches the counters it follows.
        cnt_match_p1 <= (req_next == rsp_next);
        if (push)    count[sel] <= sel_cnt + 32'd1;
        if (ovf_set) bin_overflow[sel] <= 1'b1;
        if (state == ST_SETUP) setup_idx <= setup_idx + 1'b1;
        if (state == ST_WAIT_RSP && cnt_match_p1) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_update_bin_writer.sv
module tb_update_bin_writer;

  localparam int NB = 4;
  localparam int AW = 42;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   bin_base_addr = '0;
  logic [31:0]     bin_stride_cl = '0;
  logic [AW-1:0]   status_addr = '0;
  logic            in_valid = 1'b0;
  logic [1:0]      in_bin = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            c1_almfull = 1'b0;
  logic            c1_req_valid;
  logic [AW-1:0]   c1_req_addr;
  logic [DW-1:0]   c1_req_data;
  logic            c1_rsp_valid = 1'b0;
  logic            busy;
  logic            done;
  logic [NB-1:0]   bin_overflow;
  logic [NB*32-1:0] bin_count;

  update_bin_writer #(
    .NUM_BINS(NB), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(64), .ALMFULL_SLACK(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .bin_base_addr(bin_base_addr), .bin_stride_cl(bin_stride_cl), .status_addr(status_addr),
    .in_valid(in_valid), .in_bin(in_bin), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .c1_almfull(c1_almfull), .c1_req_valid(c1_req_valid),
    .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data), .c1_rsp_valid(c1_rsp_valid),
    .busy(busy), .done(done), .bin_overflow(bin_overflow), .bin_count(bin_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of writes the model says must appear, in order.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  int pending   = 0;
  bit rsp_en    = 1'b1;
  int done_cnt  = 0;
  int done_base = 0;
  int req_seen  = 0;

  // Model of the job: configuration and per-bin fill.
  logic [AW-1:0] m_base;
  logic [AW-1:0] m_stat;
  logic [31:0]   m_stride;
  int unsigned   m_count[NB];
  logic [NB-1:0] m_ovf;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] line(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic model_line(input int bin, input logic [DW-1:0] d);
    if (bin < NB) begin
      if (m_count[bin] < m_stride) begin
        exp_addr_q.push_back(m_base + AW'(bin) * AW'(m_stride) + AW'(m_count[bin]));
        exp_data_q.push_back(d);
        m_count[bin]++;
      end else begin
        m_ovf[bin] = 1'b1;
      end
    end
  endtask

  task automatic model_status();
    logic [DW-1:0] s;
    logic [31:0]   sum;
    s   = '0;
    sum = '0;
    s[31:0] = 32'h1;
    for (int i = 0; i < NB; i++) begin
      s[64 + 32*i +: 32] = 32'(m_count[i]);
      sum = sum + 32'(m_count[i]);
    end
    s[63:32] = sum;
    exp_addr_q.push_back(m_stat);
    exp_data_q.push_back(s);
  endtask

  // Compare process: every request the DUT issues is matched against the model.
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (c1_req_valid) begin
      req_seen++;
      pending++;
      obs_addr.push_back(c1_req_addr);
      obs_data.push_back(c1_req_data);
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %0h expected no request", c1_req_addr);
      end else begin
        chk("req_addr", DW'(c1_req_addr), DW'(exp_addr_q.pop_front()));
        chk("req_data", c1_req_data, exp_data_q.pop_front());
      end
    end
  end

  // Auto responder: one response per observed request.
  always @(negedge clk) begin
    if (rsp_en) begin
      if (pending > 0) begin
        c1_rsp_valid = 1'b1;
        pending--;
      end else begin
        c1_rsp_valid = 1'b0;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] b, input logic [31:0] s, input logic [AW-1:0] st);
    @(negedge clk);
    bin_base_addr = b;
    bin_stride_cl = s;
    status_addr   = st;
    start         = 1'b1;
    m_base = b; m_stride = s; m_stat = st; m_ovf = '0;
    for (int i = 0; i < NB; i++) m_count[i] = 0;
    obs_addr.delete();
    obs_data.delete();
    done_base = done_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; holds the item until the DUT accepts it.
  task automatic send(input bit v, input int bin, input logic [DW-1:0] d, input bit last);
    int w;
    w = 0;
    in_valid = v; in_bin = 2'(bin); in_data = d; in_last = last;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      if (v) model_line(bin, d);
      if (last) model_status();
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int w;
    logic [NB*32-1:0] exp_cnt;
    w = 0;
    while (done_cnt == done_base && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < NB; i++) exp_cnt[32*i +: 32] = 32'(m_count[i]);
    chk({tag, "_done_pulses"}, DW'(done_cnt - done_base), DW'(1));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_bin_count"}, DW'(bin_count), DW'(exp_cnt));
    chk({tag, "_overflow"}, DW'(bin_overflow), DW'(m_ovf));
    chk({tag, "_exp_left"}, DW'(exp_addr_q.size()), DW'(0));
  endtask

  task automatic job_basic(input string tag);
    logic [DW-1:0] sd;
    start_job(42'h1000, 32'd4, 42'h2000);
    for (int k = 0; k < 3; k++) send(1'b1, 2, line(k), 1'b0);
    send(1'b0, 0, '0, 1'b1);
    finish_job(tag);
    chk({tag, "_nreq"}, DW'(obs_addr.size()), DW'(4));
    if (obs_addr.size() >= 4) begin
      chk({tag, "_addr0"}, DW'(obs_addr[0]), DW'(42'h1008));
      chk({tag, "_addr1"}, DW'(obs_addr[1]), DW'(42'h1009));
      chk({tag, "_addr2"}, DW'(obs_addr[2]), DW'(42'h100A));
      chk({tag, "_addr_status"}, DW'(obs_addr[3]), DW'(42'h2000));
      sd = obs_data[3];
      chk({tag, "_status_flag"}, DW'(sd[31:0]), DW'(1));
      chk({tag, "_status_sum"}, DW'(sd[63:32]), DW'(3));
      chk({tag, "_status_bin2"}, DW'(sd[159:128]), DW'(3));
      chk({tag, "_status_bin0"}, DW'(sd[95:64]), DW'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w;
    int seen0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_req_valid", DW'(c1_req_valid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_overflow", DW'(bin_overflow), DW'(0));
    chk("rst_bin_count", DW'(bin_count), DW'(0));
    chk("rst_req_addr", DW'(c1_req_addr), DW'(0));
    chk("rst_req_data", c1_req_data, DW'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic job: 3 lines to bin 2 then flush
    job_basic("t1");

    // Overflow: stride 2, 3 lines to bin 1
    start_job(42'h1000, 32'd2, 42'h2000);
    for (int j = 0; j < 3; j++) send(1'b1, 1, line(10 + j), 1'b0);
    send(1'b0, 0, '0, 1'b1);
    finish_job("t2");
    chk("t2_overflow_lit", DW'(bin_overflow), DW'(4'b0010));
    chk("t2_count1_lit", DW'(bin_count[63:32]), DW'(2));
    if (obs_addr.size() >= 2) begin
      chk("t2_addr0", DW'(obs_addr[0]), DW'(42'h1002));
      chk("t2_addr1", DW'(obs_addr[1]), DW'(42'h1003));
    end

    // Backpressure: almfull held for 100 cycles while streaming
    start_job(42'h4000, 32'd100, 42'h8000);
    c1_almfull = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    seen0 = req_seen;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      if (k < 70) begin
        in_valid = 1'b1; in_bin = 2'(k % 4); in_data = line(100 + k); in_last = 1'b0;
        if (in_ready) begin
          model_line(k % 4, line(100 + k));
          k++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_accepted_while_held", DW'(k), DW'(56));
    chk("t3_in_ready_low", DW'(in_ready), DW'(0));
    chk("t3_no_req_while_held", DW'(req_seen - seen0), DW'(0));
    c1_almfull = 1'b0;
    while (k < 70) begin
      send(1'b1, k % 4, line(100 + k), 1'b0);
      k++;
    end
    send(1'b0, 0, '0, 1'b1);
    finish_job("t3");
    chk("t3_nreq", DW'(obs_addr.size()), DW'(71));

    // Line and flush in the same cycle
    start_job(42'h5000, 32'd8, 42'h6000);
    send(1'b1, 0, line(200), 1'b1);
    finish_job("t4");
    if (obs_addr.size() >= 2) begin
      chk("t4_line_first", DW'(obs_addr[0]), DW'(42'h5000));
      chk("t4_status_second", DW'(obs_addr[1]), DW'(42'h6000));
    end

    // Withheld responses, and a response coinciding with the status request
    start_job(42'h1000, 32'd4, 42'h3000);
    rsp_en = 1'b0;
    c1_rsp_valid = 1'b0;
    seen0 = req_seen;
    send(1'b1, 3, line(300), 1'b0);
    send(1'b1, 3, line(301), 1'b0);
    w = 0;
    while (req_seen < seen0 + 2 && w < 100) begin @(negedge clk); w++; end
    c1_almfull = 1'b1;
    send(1'b0, 0, '0, 1'b1);
    repeat (6) @(negedge clk);
    c1_almfull = 1'b0;
    c1_rsp_valid = 1'b1;
    pending--;
    @(negedge clk);
    c1_rsp_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_done_while_waiting", DW'(done_cnt - done_base), DW'(0));
    chk("t5_busy_while_waiting", DW'(busy), DW'(1));
    rsp_en = 1'b1;
    finish_job("t5");
    repeat (10) @(negedge clk);
    chk("t5_single_done", DW'(done_cnt - done_base), DW'(1));

    // Reset while running with 10 lines buffered
    start_job(42'h1000, 32'd16, 42'h3000);
    c1_almfull = 1'b1;
    for (int j = 0; j < 10; j++) send(1'b1, 0, line(400 + j), 1'b0);
    reset = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk);
    #1;
    chk("t6_req_valid_after_rst", DW'(c1_req_valid), DW'(0));
    chk("t6_busy_after_rst", DW'(busy), DW'(0));
    chk("t6_in_ready_after_rst", DW'(in_ready), DW'(0));
    chk("t6_count_after_rst", DW'(bin_count), DW'(0));
    @(negedge clk);
    pending = 0;
    reset = 1'b0;
    c1_almfull = 1'b0;
    seen0 = req_seen;
    repeat (20) @(negedge clk);
    chk("t6_fifo_emptied", DW'(req_seen - seen0), DW'(0));
    job_basic("t6_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
